// File: rtl/frequency_generator_pkg.sv
// Shared definitions for the frequency generator.
//   fg_state_e  : generator FSM states
//   HALF_W      : width of the half-period reload/counter
//   half_period : clock cycles per half period, floor(clock / (2 * freq))
package frequency_generator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } fg_state_e;

  localparam int unsigned HALF_W = 32;

  function automatic logic [HALF_W-1:0] half_period(input int unsigned clock_hz,
                                                    input int unsigned freq_hz);
    return HALF_W'(clock_hz / (2 * freq_hz));
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// Loadable down-counter timing one half period of the output square wave.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset (count cleared to 0)
//   load_i       : load strobe, takes priority over counting
//   load_value_i : reload value (half-period length minus one)
//   tc_o         : terminal count, high while the count is zero
module half_period_counter
  import frequency_generator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [HALF_W-1:0] load_value_i,
  output logic              tc_o
);

  logic [HALF_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - HALF_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/frequency_generator.sv
// Square-wave burst generator with two selectable tone frequencies.
// Parameters: FREQUENCY_1 / FREQUENCY_2 (Hz, FREQUENCY_2 > FREQUENCY_1), CLOCK (Hz).
// Ports:
//   clock        : system clock, rising edge
//   clear        : asynchronous active-high reset
//   enable       : generator enable, low forces idle (no done pulse)
//   start        : one-cycle pulse starting a burst (ignored while busy)
//   select       : tone select, 0 = FREQUENCY_1, 1 = FREQUENCY_2
//   burst_length : full periods per burst, 0 = continuous
//   sample_data  : generated square wave
//   busy         : high while generating (HIGH/LOW states)
//   done         : one-cycle pulse at burst completion
//   period_count : full periods emitted in the current/last burst
// Build option: FREQUENCY_GENERATOR_PERIOD_COUNT_EN exposes a saturating 32-bit
// period_count; without it period_count reads 0 and bursts terminate on an
// internal 16-bit period counter.
module frequency_generator
  import frequency_generator_pkg::*;
#(
  parameter int unsigned FREQUENCY_1 = 9000,
  parameter int unsigned FREQUENCY_2 = 20000,
  parameter int unsigned CLOCK       = 50000000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic        start,
  input  logic        select,
  input  logic [15:0] burst_length,
  output logic        sample_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] period_count
);

  // Counter counts reload..0 inclusive, so reload is one less than the length.
  localparam logic [HALF_W-1:0] RELOAD_1 = half_period(CLOCK, FREQUENCY_1) - HALF_W'(1);
  localparam logic [HALF_W-1:0] RELOAD_2 = half_period(CLOCK, FREQUENCY_2) - HALF_W'(1);

`ifdef FREQUENCY_GENERATOR_PERIOD_COUNT_EN
  localparam int unsigned CNT_W = 32;
`else
  localparam int unsigned CNT_W = 16;
`endif

  fg_state_e         state_q, state_d;
  logic              sel_q, sel_d;
  logic [15:0]       burst_q, burst_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_inc;
  logic              burst_hit;
  logic              load;
  logic [HALF_W-1:0] load_value;
  logic              tc;

  half_period_counter u_half_cnt (
    .clk_i        (clock),
    .rst_i        (clear),
    .load_i       (load),
    .load_value_i (load_value),
    .tc_o         (tc)
  );

  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign burst_hit = (burst_q != '0) && (count_inc == CNT_W'(burst_q));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    burst_d    = burst_q;
    count_d    = count_q;
    load       = 1'b0;
    load_value = sel_q ? RELOAD_2 : RELOAD_1;
    // Dropping enable wins over every transition, including a start in IDLE,
    // and leaves the period count untouched.
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = HIGH;
            sel_d      = select;
            burst_d    = burst_length;
            count_d    = '0;
            load       = 1'b1;
            load_value = select ? RELOAD_2 : RELOAD_1;
          end
        end
        HIGH: begin
          if (tc) begin
            state_d = LOW;
            load    = 1'b1;
          end
        end
        LOW: begin
          if (tc) begin
            count_d = count_inc;
            if (burst_hit) begin
              state_d = DONE;
            end else begin
              // Tone select only takes effect on a fresh period.
              state_d    = HIGH;
              sel_d      = select;
              load       = 1'b1;
              load_value = select ? RELOAD_2 : RELOAD_1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      burst_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      burst_q <= burst_d;
      count_q <= count_d;
    end
  end

  assign sample_data = (state_q == HIGH);
  assign busy        = (state_q == HIGH) || (state_q == LOW);
  assign done        = (state_q == DONE);

`ifdef FREQUENCY_GENERATOR_PERIOD_COUNT_EN
  assign period_count = count_q;
`else
  assign period_count = '0;
`endif

endmodule

// File: tb/tb_frequency_generator.sv
module tb_frequency_generator;

  logic        clock = 1'b0;
  logic        clear, enable, start, select;
  logic [15:0] burst_length;

  logic        sd_d, busy_d, done_d;
  logic [31:0] pc_d;
  logic        sd_s, busy_s, done_s;
  logic [31:0] pc_s;

  logic        obs_sd, obs_busy, obs_done;
  logic [31:0] obs_pc;
  bit          use_small = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: position within the current period plus period tally.
  int unsigned h1 = 2777, h2 = 1250;
  bit          m_active, m_done;
  int unsigned m_pos, m_half, m_periods, m_burst;

  int          tick_no = 0, start_tick = 0, done_cnt = 0, done_at = 0;
  logic        prev_sd = 1'b0;
  int          rises[$];

  always #5 clock = ~clock;

  frequency_generator dut (
    .clock(clock), .clear(clear), .enable(enable), .start(start), .select(select),
    .burst_length(burst_length), .sample_data(sd_d), .busy(busy_d), .done(done_d),
    .period_count(pc_d)
  );

  // CLOCK/(2*F): 1000/180 = 5 (floored), 1000/400 = 2
  frequency_generator #(.FREQUENCY_1(90), .FREQUENCY_2(200), .CLOCK(1000)) dut_s (
    .clock(clock), .clear(clear), .enable(enable), .start(start), .select(select),
    .burst_length(burst_length), .sample_data(sd_s), .busy(busy_s), .done(done_s),
    .period_count(pc_s)
  );

  assign obs_sd   = use_small ? sd_s   : sd_d;
  assign obs_busy = use_small ? busy_s : busy_d;
  assign obs_done = use_small ? done_s : done_d;
  assign obs_pc   = use_small ? pc_s   : pc_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pc();
`ifdef FREQUENCY_GENERATOR_PERIOD_COUNT_EN
    return m_periods;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    logic        s_en, s_st, s_sel;
    logic [15:0] s_bl;
    bit          prev_done;
    s_en = enable; s_st = start; s_sel = select; s_bl = burst_length;
    @(posedge clock);
    tick_no++;
    prev_done = m_done;
    m_done    = 1'b0;
    if (!s_en) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_pos == 2 * m_half - 1) begin
        if (m_periods != 32'hFFFF_FFFF) m_periods++;
        if (m_burst != 0 && m_periods == m_burst) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_pos  = 0;
          m_half = s_sel ? h2 : h1;
        end
      end else begin
        m_pos++;
      end
    end else if (!prev_done && s_st) begin
      m_active  = 1'b1;
      m_pos     = 0;
      m_half    = s_sel ? h2 : h1;
      m_periods = 0;
      m_burst   = s_bl;
    end
    #1;
    check("sample_data", obs_sd, m_active && (m_pos < m_half));
    check("busy", obs_busy, m_active);
    check("done", obs_done, m_done);
    check("period_count", obs_pc, exp_pc());
    if (obs_done) begin done_cnt++; done_at = tick_no; end
    if (obs_sd && !prev_sd) rises.push_back(tick_no);
    prev_sd = obs_sd;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start(input logic sel, input logic [15:0] bl);
    select = sel; burst_length = bl; start = 1'b1;
    tick();
    start_tick = tick_no;
    start = 1'b0;
  endtask

  // Asserted between edges: outputs must drop without waiting for a clock.
  task automatic do_clear();
    clear = 1'b1;
    #1;
    check("clr_sample_data", sd_d | sd_s, 1'b0);
    check("clr_busy", busy_d | busy_s, 1'b0);
    check("clr_done", done_d | done_s, 1'b0);
    check("clr_period_count", pc_d | pc_s, 32'd0);
    m_active = 1'b0; m_done = 1'b0; m_periods = 0; m_pos = 0;
    prev_sd = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    longint freq;
    clear = 1'b1; enable = 1'b0; start = 1'b0; select = 1'b0; burst_length = '0;
    m_active = 1'b0; m_done = 1'b0; m_periods = 0; m_pos = 0; m_half = h1; m_burst = 0;
    #2;
    check("rst_sample_data", obs_sd, 1'b0);
    check("rst_busy", obs_busy, 1'b0);
    check("rst_done", obs_done, 1'b0);
    check("rst_period_count", obs_pc, 32'd0);
    clear = 1'b0;
    enable = 1'b1;
    run(3);

    // Three upper-tone periods, done on cycle 7501 after start.
    done_cnt = 0;
    pulse_start(1'b1, 16'd3);
    run(7502);
    check("b3_done_cnt", done_cnt, 1);
    check("b3_done_cycle", done_at - start_tick + 1, 7501);

    // Single lower-tone period.
    done_cnt = 0;
    pulse_start(1'b0, 16'd1);
    run(5557);
    check("b1_done_cnt", done_cnt, 1);
    check("b1_done_cycle", done_at - start_tick + 1, 5555);

    // Continuous, select raised mid-HIGH of period 2.
    done_cnt = 0;
    rises.delete();
    pulse_start(1'b0, 16'd0);
    run(5654);
    select = 1'b1;
    run(7964);
    check("cont_done_cnt", done_cnt, 0);
    check("cont_rises", rises.size(), 4);
    if (rises.size() >= 4) begin
      check("cont_p1_len", rises[1] - rises[0], 5554);
      check("cont_p2_len", rises[2] - rises[1], 5554);
      check("cont_p3_len", rises[3] - rises[2], 2500);
    end
    enable = 1'b0; tick(); enable = 1'b1; tick();

    // Enable dropped at cycle 1000 of HIGH.
    done_cnt = 0;
    pulse_start(1'b1, 16'd5);
    run(999);
    enable = 1'b0;
    tick();
    check("en_drop_busy", obs_busy, 1'b0);
    check("en_drop_sd", obs_sd, 1'b0);
    enable = 1'b1;
    run(5);
    check("en_drop_done_cnt", done_cnt, 0);

    // Start while busy ignored; burst length stays at 2.
    done_cnt = 0;
    pulse_start(1'b1, 16'd2);
    run(10);
    burst_length = 16'd7; start = 1'b1; tick(); start = 1'b0;
    run(4995);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_done_cycle", done_at - start_tick + 1, 5001);

    // Clear in the middle of LOW, then no activity without a new start.
    done_cnt = 0;
    pulse_start(1'b1, 16'd3);
    run(1650);
    do_clear();
    run(20);
    check("clr_done_cnt", done_cnt, 0);

    // Ten upper-tone periods measured as a frequency.
    rises.delete();
    pulse_start(1'b1, 16'd10);
    run(25005);
    check("f2_rises", rises.size(), 10);
    if (rises.size() >= 2) begin
      freq = 64'd50000000 * (rises.size() - 1) / (rises[rises.size()-1] - rises[0]);
      check("f2_hz", freq[31:0], 20000);
    end

    // Randomized traffic on the short-period instance.
    use_small = 1'b1; h1 = 5; h2 = 2;
    do_clear();
    for (int i = 0; i < 4000; i++) begin
      enable       = ($urandom % 40) != 0;
      start        = ($urandom % 6) == 0;
      select       = $urandom % 2;
      burst_length = 16'($urandom % 4);
      if ($urandom % 300 == 0) do_clear();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 SHALL have parameter FREQUENCY_1, default 9000, lower tone frequency in Hz.
REQ-002 SHALL have parameter FREQUENCY_2, default 20000, upper tone frequency in Hz; FREQUENCY_2 > FREQUENCY_1 always.
REQ-003 SHALL have parameter CLOCK, default 50000000, clock frequency in Hz.
REQ-004 SHALL have port clock  input  1  single system clock, rising edge.
REQ-005 SHALL have port clear  input  1  asynchronous active-high reset.
REQ-006 SHALL have port enable  input  1  generator enable; low forces idle.
REQ-007 SHALL have port start  input  1  one-cycle pulse starting a burst.
REQ-008 SHALL have port select  input  1  0 = FREQUENCY_1, 1 = FREQUENCY_2.
REQ-009 SHALL have port burst_length  input  16  full periods per burst; 0 = continuous.
REQ-010 SHALL have port sample_data  output  1  generated square wave, analyzer-compatible.
REQ-011 SHALL have port busy  output  1  high while generating.
REQ-012 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-013 SHALL have port period_count  output  32  full periods emitted in current/last burst.

Function
REQ-014 SHALL use half-period reload HALF_n = CLOCK/(2*FREQUENCY_n), integer floor (defaults: HALF_1 = 2777, HALF_2 = 1250).
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-016 IDLE: sample_data=0, busy=0; start=1 with enable=1 -> HIGH next cycle, latch select and burst_length, clear period_count.
REQ-017 HIGH: sample_data=1 for exactly HALF_sel cycles, then -> LOW.
REQ-018 LOW: sample_data=0 for exactly HALF_sel cycles; at end, period_count increments.
REQ-019 End of LOW: if burst_length != 0 and period_count (after increment) == burst_length -> DONE; else -> HIGH.
REQ-020 select SHALL be resampled only at the LOW->HIGH boundary; mid-period changes SHALL NOT alter the current period.
REQ-021 DONE: done=1 for one cycle, busy=0, then IDLE; first valid start is the cycle after DONE.
REQ-022 busy SHALL be 1 in HIGH and LOW only.
REQ-023 start while busy SHALL be ignored.
REQ-024 enable=0 in any state SHALL force IDLE next cycle, sample_data=0, no done pulse; period_count retained.
REQ-025 start and enable falling in the same cycle: enable wins, stay IDLE.
REQ-026 period_count SHALL saturate at 0xFFFFFFFF in continuous mode.

Reset
REQ-027 clear=1 SHALL asynchronously force IDLE, sample_data=0, busy=0, done=0, period_count=0, half counter=0.
REQ-028 clear mid-burst SHALL abort without done; generation restarts only on a new start after clear deasserts.

Configuration
REQ-029 With FREQUENCY_GENERATOR_PERIOD_COUNT_EN defined, period_count SHALL behave per REQ-016/018/026.
REQ-030 Without FREQUENCY_GENERATOR_PERIOD_COUNT_EN, period_count SHALL be tied to 0 and burst termination SHALL use an internal 16-bit counter; all other behaviour unchanged.

Structure
REQ-031 Package frequency_generator_pkg SHALL hold the FSM state enum and the half-period constant computation function.
REQ-032 Sub-module half_period_counter (load value, load strobe, terminal-count flag) SHALL implement the down-counter.

Verification
REQ-033 Defaults, select=1, burst_length=3, start -> 3 periods of 1250 high/1250 low, done at cycle 7501 after start, period_count=3.
REQ-034 select=0, burst_length=1 -> 2777 high/2777 low, single done pulse, period_count=1.
REQ-035 burst_length=0, select toggled 0->1 mid-HIGH of period 2 -> period 2 stays 2777/2777, period 3 is 1250/1250, no done.
REQ-036 enable dropped at cycle 1000 of HIGH -> sample_data=0 and busy=0 next cycle, no done, period_count unchanged.
REQ-037 clear asserted mid-LOW -> outputs zero immediately (asynchronous); start pulse during busy -> ignored, burst length unaffected.
REQ-038 Loop-back into frequency_analyzer with 10 FREQUENCY_2 periods -> f2_value reports 20000 Hz within analyzer tolerance.
